if_fetch_ctrl: RTL

//  Instruction-fetch sequencer in front of the IF stage. Owns the architectural fetch PC and

---
 rtl/if_fetch_ctrl_pkg.sv | 26 ++
 rtl/if_fetch_ctrl_if.sv | 29 ++
 rtl/if_fetch_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned AddrW  = 64;
  localparam int unsigned InstrW = 32;
  localparam int unsigned HoldW  = 3;

  // Fetch may advance only while hold_code is strictly below this level.
  localparam logic [HoldW-1:0] HoldCodeIf = 3'd1;

  // Legal fetch window; anything outside it, or misaligned, is a bad PC.
  localparam logic [AddrW-1:0] BasePc = 64'h0000_0000_8000_0000;
  localparam logic [AddrW-1:0] PcMax  = 64'h0000_0000_FFFF_FFFC;

  localparam logic MaskEn  = 1'b1;
  localparam logic MaskDis = 1'b0;

  localparam logic [InstrW-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-bus handshake: single-outstanding req/gnt/rvalid.
interface if_fetch_ctrl_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) ();

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the instruction bus and presents
// one buffered instruction to the IF stage. Redirects squash stale in-flight fetches.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W       = AddrW,
  parameter int unsigned       INSTR_W      = InstrW,
  parameter int unsigned       HOLD_W       = HoldW,
  parameter logic [HOLD_W-1:0] HOLD_CODE_IF = HoldCodeIf,
  parameter logic [ADDR_W-1:0] BASE_PC      = BasePc,
  parameter logic [ADDR_W-1:0] PC_MAX       = PcMax
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HOLD_W-1:0]   hold_code,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_pc,
  if_fetch_ctrl_if.master     ibus,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic                instr_valid_o,
  output logic                instr_mask_o
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic               kill_q;
  logic               ibuf_vld_q;
  logic [ADDR_W-1:0]  ibuf_pc_q;
  logic [INSTR_W-1:0] ibuf_instr_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               fetch_go;
  logic               cur_bad;
  logic               consume;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  launch_pc;
  logic               launch_ok;
  logic [ADDR_W-1:0]  redo_pc;
  logic               redo_bad;

  function automatic logic pc_bad(input logic [ADDR_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < BASE_PC) || (pc > PC_MAX);
  endfunction

  // Decode hold/consume/launch conditions from current state and inputs.
  always_comb begin
    fetch_go  = hold_code < HOLD_CODE_IF;
    cur_bad   = pc_bad(fetch_pc_q);
    // A bad-PC entry is never consumed; only a redirect moves past it.
    consume   = ibuf_vld_q && fetch_go && !jump_en && !cur_bad;
    pc_plus4  = fetch_pc_q + ADDR_W'(4);
    launch_pc = consume ? pc_plus4 : fetch_pc_q;
    launch_ok = fetch_go && (!ibuf_vld_q || consume) && !pc_bad(launch_pc);
    // Re-fetch target after a discarded response: a same-cycle jump wins.
    redo_pc   = jump_en ? jump_pc : fetch_pc_q;
    redo_bad  = pc_bad(redo_pc);
  end

  // Fetch FSM with PC, kill flag, instruction buffer and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= BASE_PC;
      kill_q       <= 1'b0;
      ibuf_vld_q   <= 1'b0;
      ibuf_pc_q    <= '0;
      ibuf_instr_q <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
    end else begin
      if (consume) begin
        ibuf_vld_q <= 1'b0;
        fetch_pc_q <= pc_plus4;
      end
      if (jump_en) begin
        fetch_pc_q <= jump_pc;
        ibuf_vld_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          // A redirect edge only retargets; the request goes out on a later cycle.
          if (!jump_en) begin
            if (launch_ok) begin
              state_q <= StReq;
              req_q   <= 1'b1;
              addr_q  <= launch_pc;
            end else if (fetch_go && !ibuf_vld_q && cur_bad) begin
              ibuf_pc_q    <= fetch_pc_q;
              ibuf_instr_q <= ZeroWord;
              ibuf_vld_q   <= 1'b1;
            end
          end
        end
        StReq: begin
          // Address must stay stable until granted, so a redirect marks the fetch stale.
          if (jump_en) kill_q <= 1'b1;
          if (ibus.gnt) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (ibus.rvalid) begin
            if (kill_q || jump_en) begin
              kill_q <= 1'b0;
              if (redo_bad) begin
                state_q <= StIdle;
              end else begin
                state_q <= StReq;
                req_q   <= 1'b1;
                addr_q  <= redo_pc;
              end
            end else begin
              ibuf_pc_q    <= fetch_pc_q;
              ibuf_instr_q <= ibus.rdata;
              ibuf_vld_q   <= 1'b1;
              state_q      <= StIdle;
            end
          end else if (jump_en) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ibus.req      = req_q;
  assign ibus.addr     = addr_q;
  assign pc_o          = ibuf_pc_q;
  assign instr_o       = ibuf_instr_q;
  assign instr_valid_o = ibuf_vld_q;
  assign instr_mask_o  = ibuf_vld_q ? MaskDis : MaskEn;

  // Read data is only legal while a granted fetch is outstanding.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    ibus.rvalid |-> (state_q == StWait));

endmodule
